// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the boot-time program loader
//
// Contents:
//   loader_state_t    : loader FSM states (IDLE, LOAD, DONE)
//   END_WORD_DEFAULT  : default terminator word that ends a load
//   CLKS_PER_BIT      : baud-derived cycles per UART bit, shared with the UART blocks
//   CLKS_PER_HALF_BIT : mid-bit sampling point used by the receiver
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam logic [31:0] END_WORD_DEFAULT  = 32'hFFFF_FFFF;

    localparam int          CLKS_PER_BIT      = 5208;
    localparam int          CLKS_PER_HALF_BIT = CLKS_PER_BIT / 2;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - single-register sampler with rising-edge output
//
// Ports:
//   CLK  in  : clock, posedge
//   RST  in  : asynchronous active-high reset
//   sig  in  : level or pulse input to watch
//   rise out : high for one cycle when the registered sample goes 0 -> 1
module edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sig_q    <= 1'b0;
            sig_prev <= 1'b0;
        end else begin
            sig_q    <= sig;
            sig_prev <= sig_q;
        end
    end

    assign rise = sig_q & ~sig_prev;

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - packs UART bytes MSB-first into 32-bit words and writes them to instruction memory
//
// Ports:
//   CLK, RST              : clock (posedge) and asynchronous active-high reset
//   start, stop           : level/pulse controls; rising edge starts/restarts or aborts a load
//   rx_data, rx_valid     : byte stream from the UART receiver, one-cycle strobe per byte
//   wr_en/wr_addr/wr_data : one-cycle instruction-memory write port
//   busy, done            : high in LOAD / DONE
//   word_count            : words written by the current or last load
//   err_timeout           : sticky, a partial word was dropped after an inter-byte stall
//   err_overflow          : sticky, a word arrived after memory was full
module inst_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] END_WORD     = END_WORD_DEFAULT,
    parameter int          BYTE_TIMEOUT = 200000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  stop,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err_timeout,
    output logic                  err_overflow
);

    localparam int                  TW       = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [TW-1:0]       TMO_LAST = TW'(BYTE_TIMEOUT - 1);

    loader_state_t state;
    logic          start_rise;
    logic          stop_rise;
    logic [1:0]    byte_idx;
    logic [31:0]   shift_reg;
    logic [31:0]   next_word;
    logic [TW-1:0] tmo_cnt;

    edge_detect u_start_edge (
        .CLK  (CLK),
        .RST  (RST),
        .sig  (start),
        .rise (start_rise)
    );

    edge_detect u_stop_edge (
        .CLK  (CLK),
        .RST  (RST),
        .sig  (stop),
        .rise (stop_rise)
    );

    // Word as it looks once the byte in flight is shifted in; on the 4th byte it is complete.
    assign next_word = {shift_reg[23:0], rx_data};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            word_count   <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            byte_idx     <= '0;
            shift_reg    <= '0;
            tmo_cnt      <= '0;
        end else begin
            wr_en <= 1'b0;
            // Stop only matters while loading; outside LOAD a coincident start still wins.
            if (state == LOAD && stop_rise) begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                byte_idx  <= '0;
                shift_reg <= '0;
                tmo_cnt   <= '0;
            end else if (start_rise) begin
                state        <= LOAD;
                busy         <= 1'b1;
                done         <= 1'b0;
                word_count   <= '0;
                byte_idx     <= '0;
                shift_reg    <= '0;
                tmo_cnt      <= '0;
                err_timeout  <= 1'b0;
                err_overflow <= 1'b0;
            end else if (state == LOAD) begin
                if (rx_valid) begin
                    tmo_cnt   <= '0;
                    shift_reg <= next_word;
                    byte_idx  <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (next_word == END_WORD) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (word_count == CAPACITY) begin
                            err_overflow <= 1'b1;
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            wr_en      <= 1'b1;
                            wr_addr    <= word_count[ADDR_WIDTH-1:0];
                            wr_data    <= next_word;
                            word_count <= word_count + (ADDR_WIDTH+1)'(1);
                        end
                    end
                end else if (byte_idx != 2'd0) begin
                    // Stall inside a partial word: drop it after BYTE_TIMEOUT idle cycles.
                    if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        byte_idx    <= '0;
                        shift_reg   <= '0;
                        tmo_cnt     <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - self-checking bench for inst_loader
module tb_inst_loader;

    localparam int AW  = 2;
    localparam int TMO = 20;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;
    logic          err_timeout;
    logic          err_overflow;

    inst_loader #(
        .ADDR_WIDTH   (AW),
        .END_WORD     (32'hFFFF_FFFF),
        .BYTE_TIMEOUT (TMO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .stop         (stop),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];

    always @(negedge CLK) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    typedef struct {
        logic        do_start;
        logic [31:0] word;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_count;
        logic        exp_done;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bytes(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = w[31 - 8*i -: 8];
            cyc(1);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(1);
    endtask

    task automatic check_write(input string name, input int n0, input logic [31:0] addr, input logic [31:0] data);
        check({name, "_nwr"}, 32'(log_addr.size()), 32'(n0 + 1));
        if (log_addr.size() > n0) begin
            check({name, "_addr"}, 32'(log_addr[n0]), addr);
            check({name, "_data"}, log_data[n0], data);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;

        // Load of three words + end marker, then an overflow run with capacity 4.
        vecs[0] = '{1'b1, 32'h0000_00EC, 1'b1, 32'd0, 32'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_00F0, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h2000_0020, 1'b1, 32'd2, 32'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd3, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h0101_0101, 1'b1, 32'd0, 32'd1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0202_0202, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h0303_0303, 1'b1, 32'd2, 32'd3, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h0404_0404, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h0505_0505, 1'b0, 32'd0, 32'd4, 1'b1, 1'b1};

        // Reset state
        #1;
        check("rst_wr_en",   32'(wr_en), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_done",    32'(done), 32'd0);
        check("rst_count",   32'(word_count), 32'd0);
        check("rst_errs",    32'({err_timeout, err_overflow}), 32'd0);
        cyc(2);
        RST = 1'b0;
        cyc(1);

        // Table-driven word loads
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_start) begin
                start = 1'b1;
                cyc(1);
                check($sformatf("v%0d_busy_lat1", i), 32'(busy), 32'd0);
                start = 1'b0;
                cyc(1);
                check($sformatf("v%0d_busy_lat2", i), 32'(busy), 32'd1);
                check($sformatf("v%0d_count0", i), 32'(word_count), 32'd0);
            end
            n0 = log_addr.size();
            send_bytes(vecs[i].word, 4);
            cyc(1);
            if (vecs[i].exp_wr)
                check_write($sformatf("v%0d", i), n0, vecs[i].exp_addr, vecs[i].word);
            else
                check($sformatf("v%0d_nowr", i), 32'(log_addr.size()), 32'(n0));
            check($sformatf("v%0d_count", i), 32'(word_count), vecs[i].exp_count);
            check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(!vecs[i].exp_done));
            check($sformatf("v%0d_ovf", i), 32'(err_overflow), 32'(vecs[i].exp_ovf));
        end

        // Inter-byte timeout discards a partial word
        pulse_start();
        check("tmo_ovf_cleared", 32'(err_overflow), 32'd0);
        check("tmo_count0", 32'(word_count), 32'd0);
        n0 = log_addr.size();
        send_bytes(32'h1234_0000, 2);
        cyc(TMO - 2);
        check("tmo_not_yet", 32'(err_timeout), 32'd0);
        cyc(3);
        check("tmo_flag", 32'(err_timeout), 32'd1);
        check("tmo_nowr", 32'(log_addr.size()), 32'(n0));
        check("tmo_busy", 32'(busy), 32'd1);
        send_bytes(32'hAABB_CCDD, 4);
        cyc(1);
        check_write("tmo_next", n0, 32'd0, 32'hAABB_CCDD);

        // Stop mid-word
        pulse_start();
        n0 = log_addr.size();
        send_bytes(32'h1122_3344, 4);
        send_bytes(32'h5566_0000, 2);
        pulse_stop();
        check("stop_done", 32'(done), 32'd1);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_count", 32'(word_count), 32'd1);
        check_write("stop", n0, 32'd0, 32'h1122_3344);

        // Stop edge in the same cycle as the 4th byte wins
        pulse_start();
        n0 = log_addr.size();
        send_bytes(32'h5566_0000, 2);
        rx_valid = 1'b1; rx_data = 8'h77; stop = 1'b1;
        cyc(1);
        rx_data = 8'h88; stop = 1'b0;
        cyc(1);
        rx_valid = 1'b0;
        cyc(1);
        check("sim_done", 32'(done), 32'd1);
        check("sim_nowr", 32'(log_addr.size()), 32'(n0));
        check("sim_count", 32'(word_count), 32'd0);

        // Start edge mid-load restarts counting at address 0
        pulse_start();
        n0 = log_addr.size();
        send_bytes(32'h0102_0304, 4);
        cyc(1);
        check_write("rs_first", n0, 32'd0, 32'h0102_0304);
        send_bytes(32'h0506_0000, 2);
        pulse_start();
        check("rs_count0", 32'(word_count), 32'd0);
        check("rs_busy", 32'(busy), 32'd1);
        n1 = log_addr.size();
        send_bytes(32'h0A0B_0C0D, 4);
        cyc(1);
        check_write("rs_next", n1, 32'd0, 32'h0A0B_0C0D);
        check("rs_count1", 32'(word_count), 32'd1);

        // Reset between bytes 2 and 3
        pulse_start();
        send_bytes(32'h0F0E_0D0C, 4);
        send_bytes(32'h1020_0000, 2);
        RST = 1'b1;
        #1;
        check("mr_wr_en", 32'(wr_en), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_count", 32'(word_count), 32'd0);
        check("mr_addr", 32'(wr_addr), 32'd0);
        check("mr_data", wr_data, 32'd0);
        n0 = log_addr.size();
        cyc(2);
        RST = 1'b0;
        send_bytes(32'h3040_5060, 4);
        cyc(2);
        check("mr_nowr", 32'(log_addr.size()), 32'(n0));
        check("mr_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
